// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer UART dump: address width, default frame size,
// baud divider width and FSM state encoding.
package fb_pkg;

  localparam int unsigned FRAME_PIXELS_DEFAULT = 307200;
  localparam int unsigned FB_ADDR_W            = 19;
  localparam int unsigned BYTE_W               = 8;
  localparam int unsigned DIV_W                = 16;
  localparam int unsigned BIT_CNT_W            = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_TX    = 2'd3;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: load starts a start bit immediately; every bit lasts div cycles;
// tx_done is high during the last cycle of the stop bit.
module uart_tx_byte
  import fb_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] data,
  input  logic [DIV_W-1:0]  div,
  output logic              tx,
  output logic              tx_done
);

  localparam logic [BIT_CNT_W-1:0] STOP_BIT  = BIT_CNT_W'(9);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(8);

  logic                 active_q, active_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end_c;

  assign bit_end_c = active_q && (baud_q == div - DIV_W'(1));
  assign tx_done   = bit_end_c && (bit_q == STOP_BIT);
  assign tx        = tx_q;

  // Bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (bit_end_c) begin
        baud_d = '0;
        if (bit_q == STOP_BIT) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + BIT_CNT_W'(1);
          if (bit_q < LAST_DATA) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        baud_d = baud_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/frame_dump_tx.sv
// Streams a framebuffer out of a UART, one byte per address, with a registered-output
// BRAM read path. The FSM owns addressing, abort handling and completion status.
module frame_dump_tx
  import fb_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [FB_ADDR_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0]    rd_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [FB_ADDR_W-1:0] byte_count
);

  localparam int unsigned          DIV       = CLK_HZ / BAUD;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_PIXELS - 1);

  logic [1:0]           state_q, state_d;
  logic [FB_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [FB_ADDR_W-1:0] byte_count_q, byte_count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 load_c;
  logic                 tx_done_c;

  uart_tx_byte u_ser (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (load_c),
    .data     (rd_data),
    .div      (DIV_W'(DIV)),
    .tx       (tx),
    .tx_done  (tx_done_c)
  );

  // ADDR waits out the BRAM latency; LATCH loads the serializer with the fetched byte.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    byte_count_d = byte_count_q;
    done_d       = 1'b0;
    abort_d      = abort_q;
    load_c       = 1'b0;

    if ((state_q != ST_IDLE) && abort) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ADDR;
          rd_addr_d    = '0;
          byte_count_d = '0;
        end
      end
      ST_ADDR:  state_d = ST_LATCH;
      ST_LATCH: begin
        load_c  = 1'b1;
        state_d = ST_TX;
      end
      ST_TX: begin
        if (tx_done_c) begin
          byte_count_d = byte_count_q + FB_ADDR_W'(1);
          if (rd_addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (abort_q || abort) begin
            state_d = ST_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + FB_ADDR_W'(1);
            state_d   = ST_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) abort_d = 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      byte_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      byte_count_q <= byte_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign byte_count = byte_count_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frame_dump_tx.sv
// Bench for frame_dump_tx at DIV=10, 4-byte frame: expected line waveform and status
// are derived from a timeline of byte slots (2-cycle lead, 100-cycle bytes, 2-cycle gaps).
module tb_frame_dump_tx;

  localparam int NPIX     = 4;
  localparam int BIT_CYC  = 10;
  localparam int BYTE_CYC = 10 * BIT_CYC;
  localparam int LEAD     = 2;
  localparam int PITCH    = BYTE_CYC + 2;
  localparam int MAXD     = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data  = 8'h00;
  logic        tx, busy, done;
  logic [18:0] byte_count;

  logic [7:0] mem [NPIX];
  int checks = 0;
  int errors = 0;

  int d_base [MAXD];
  int d_last [MAXD];
  bit d_full [MAXD];
  int n_dumps;

  frame_dump_tx #(.CLK_HZ(1000), .BAUD(100), .FRAME_PIXELS(NPIX)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Registered-output BRAM model
  always @(posedge CLOCK_50) rd_data <= mem[rd_addr[1:0]];

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic logic uart_bit(input int o, input logic [7:0] b);
    int n;
    n = o / BIT_CYC;
    if (n == 0) return 1'b0;
    if (n >= 9) return 1'b1;
    return b[n-1];
  endfunction

  // Dump timeline: dump starts at the edge sampling start; next dump follows if start still held.
  function automatic void plan(input int ncyc, input int abort_at, input int hold_until);
    int base;
    int last;
    base    = 0;
    n_dumps = 0;
    while (n_dumps < MAXD) begin
      last = NPIX - 1;
      if (abort_at >= base && abort_at < base + LEAD + (NPIX - 1) * PITCH + BYTE_CYC)
        for (int b = NPIX - 1; b >= 0; b--)
          if (base + LEAD + b * PITCH + BYTE_CYC > abort_at) last = b;
      d_base[n_dumps] = base;
      d_last[n_dumps] = last;
      d_full[n_dumps] = (last == NPIX - 1);
      n_dumps++;
      base = base + LEAD + last * PITCH + BYTE_CYC + 1;
      if (base > hold_until || base >= ncyc) break;
    end
  endfunction

  task automatic check_sample(input int k);
    int   d;
    int   e_end;
    int   ends;
    int   s;
    logic etx;
    d    = 0;
    ends = 0;
    etx  = 1'b1;
    for (int i = 1; i < n_dumps; i++) if (d_base[i] <= k) d = i;
    e_end = d_base[d] + LEAD + d_last[d] * PITCH + BYTE_CYC;
    for (int b = 0; b <= d_last[d]; b++) begin
      s = d_base[d] + LEAD + b * PITCH;
      if (k >= s + BYTE_CYC) ends++;
      else if (k >= s) etx = uart_bit(k - s, mem[b]);
    end
    chk("tx", k, 32'(tx), 32'(etx));
    chk("busy", k, 32'(busy), 32'(k < e_end));
    chk("done", k, 32'(done), 32'(d_full[d] && (k == e_end)));
    chk("byte_count", k, 32'(byte_count), 32'(ends));
    chk("rd_addr", k, 32'(rd_addr), 32'((ends < d_last[d]) ? ends : d_last[d]));
  endtask

  // Called just after a falling edge with the DUT idle; sample k follows rising edge k.
  task automatic run_dump(input int ncyc, input int abort_at, input int hold_until);
    plan(ncyc, abort_at, hold_until);
    start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge CLOCK_50);
      check_sample(k);
      if (k >= hold_until) start = 1'b0;
      abort = (k == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx"}, -1, 32'(tx), 32'(1));
    chk({tag, "_busy"}, -1, 32'(busy), 32'(0));
    chk({tag, "_done"}, -1, 32'(done), 32'(0));
    chk({tag, "_rd_addr"}, -1, 32'(rd_addr), 32'(0));
    chk({tag, "_byte_count"}, -1, 32'(byte_count), 32'(0));
  endtask

  task automatic load_fixed();
    mem[0] = 8'h55;
    mem[1] = 8'hA3;
    mem[2] = 8'h00;
    mem[3] = 8'hFF;
  endtask

  initial begin
    load_fixed();
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check_idle("reset");
    reset = 1'b0;
    @(negedge CLOCK_50);
    check_idle("post_reset");

    // Single-cycle start, full frame
    run_dump(420, -1, 0);

    // start held: one dump to done, then an immediate second dump
    run_dump(830, -1, 500);

    // abort during data bits of byte 1
    run_dump(420, 150, 0);

    // Random frame contents and random abort points
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      run_dump(420, int'($urandom_range(0, 450)), 0);
    end

    // Reset in the middle of byte 2's start bit, then a clean re-dump
    load_fixed();
    run_dump(211, -1, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check_idle("mid_reset");
    reset = 1'b0;
    run_dump(420, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_dump_tx.md
FRAME_DUMP_TX -- requirements
Module: frame_dump_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate; bit period DIV = CLK_HZ/BAUD, integer-truncated (434 at defaults).
REQ-003 The block SHALL have parameter FRAME_PIXELS, default 307200, meaning the number of bytes per dump; addresses run 0..FRAME_PIXELS-1.
REQ-004 The block SHALL have port CLOCK_50  input  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  level; a high sample in IDLE begins a dump.
REQ-007 The block SHALL have port abort  input  1  level; requests early termination of a dump.
REQ-008 The block SHALL have port rd_addr  output  19  framebuffer read address, registered.
REQ-009 The block SHALL have port rd_data  input  8  framebuffer byte, valid one clock after rd_addr (registered-output BRAM).
REQ-010 The block SHALL have port tx  output  1  UART 8N1 serial line, idle high.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on completion of a full frame.
REQ-013 The block SHALL have port byte_count  output  19  number of bytes whose stop bit has completed in the current or last dump.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, LATCH, TX.
REQ-015 IDLE with start=1 SHALL go to ADDR, set rd_addr=0, and clear byte_count, all at the sampling edge.
REQ-016 ADDR SHALL go unconditionally to LATCH after one cycle.
REQ-017 LATCH SHALL capture rd_data into the shift register, drive tx low (start bit), and enter TX at the same edge; tx therefore falls 2 cycles after the edge that sampled start.
REQ-018 TX SHALL send the start bit, then data bits LSB first, then one stop bit (high); each bit lasts exactly DIV cycles, 10*DIV cycles per byte.
REQ-019 At the end of the stop bit, byte_count SHALL increment by 1.
REQ-020 At the end of the stop bit, if rd_addr = FRAME_PIXELS-1 the FSM SHALL go to IDLE and pulse done for exactly one cycle.
REQ-021 At the end of the stop bit, if abort was seen and rd_addr is not the last address, the FSM SHALL go to IDLE with no done pulse.
REQ-022 At the end of the stop bit, in all other cases the FSM SHALL increment rd_addr and go to ADDR, giving exactly 2 idle-high cycles between a stop bit and the next start bit.
REQ-023 abort SHALL be latched whenever busy=1 and cleared on entry to IDLE; a byte in flight SHALL always complete, with no truncated frame on tx.
REQ-024 The block SHALL ignore start while busy=1; start held high through done SHALL begin a new dump on the first IDLE cycle.
REQ-025 rd_addr SHALL hold its last value while in IDLE.

Reset
REQ-026 On reset the block SHALL set the state to IDLE, tx=1, busy=0, done=0, rd_addr=0, byte_count=0, and clear the baud counter, bit counter and abort latch, taking effect at the next edge regardless of state, including mid-bit.

Structure
REQ-027 Package fb_pkg SHALL hold FRAME_PIXELS_DEFAULT (307200), FB_ADDR_W (19), and the FSM state encoding.
REQ-028 The bit serializer SHALL be sub-module uart_tx_byte, with inputs load, data[7:0] and div and outputs tx and tx_done (one-cycle pulse at the end of the stop bit); the FSM SHALL own addressing and sequencing.

Verification (CLK_HZ=1000, BAUD=100, DIV=10, FRAME_PIXELS=4, memory 0x55,0xA3,0x00,0xFF)
REQ-029 Reset pulse -> next cycle tx=1, busy=0, done=0, rd_addr=0, byte_count=0.
REQ-030 One-cycle start -> tx falls 2 cycles later; decoded bytes are 0x55, 0xA3, 0x00, 0xFF; each bit is exactly 10 cycles; 2-cycle gaps between bytes; done high 1 cycle after the last stop bit; byte_count=4.
REQ-031 start held high for the whole run -> exactly one dump until done, then a second dump from address 0 beginning the cycle after return to IDLE.
REQ-032 abort pulse during the data bits of byte 1 (0xA3) -> 0xA3 completes with stop bit; IDLE; byte_count=2; done never asserts.
REQ-033 reset asserted mid-start-bit of byte 2 -> tx=1 next cycle, busy=0, byte_count=0; a subsequent start re-dumps from 0x55.
